pll_reset_sequencer: RTL and testbench

- Sequences the iCE40 PLL at power-up and holds the SoC in reset until the PLL output is trustworthy.
- Drives the PLL RESETB pin and filters the asynchronous PLL LOCK output.
- Produces a clean soc_reset / ready pair, re-resets the PLL on lock timeout, and counts retries and lock losses for debug.
- Clocked by the 12 MHz board reference clock, upstream of the PLL wrapper.

---
 rtl/pll_reset_sequencer_if.sv | 36 +++
 rtl/pll_reset_sequencer.sv | 112 +++++++++++
 tb/tb_pll_reset_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and its surroundings (PLL pins, SoC reset, debug).
// master is the sequencer side; slave is the PLL/SoC/debug side that consumes its outputs.
interface pll_reset_sequencer_if #(
    parameter int ERR_W = 8
);
    logic             pll_locked_async;
    logic             clear_counts;
    logic             pll_resetb;
    logic             soc_reset;
    logic             ready;
    logic [2:0]       state;
    logic [ERR_W-1:0] retry_count;
    logic [ERR_W-1:0] lock_loss_count;

    modport master (
        input  pll_locked_async,
        input  clear_counts,
        output pll_resetb,
        output soc_reset,
        output ready,
        output state,
        output retry_count,
        output lock_loss_count
    );

    modport slave (
        output pll_locked_async,
        output clear_counts,
        input  pll_resetb,
        input  soc_reset,
        input  ready,
        input  state,
        input  retry_count,
        input  lock_loss_count
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Power-up sequencer for the iCE40 PLL: pulses RESETB, qualifies a synchronized LOCK,
// and releases the SoC reset only after lock has been stable and a hold time has passed.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 4096,
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int RESET_HOLD_CYCLES  = 64,
    parameter int CNT_W              = 16,
    parameter int ERR_W              = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    pll_reset_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        HOLD      = 3'd3,
        RUN       = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               locked_s;
    logic               pll_resetb_q, soc_reset_q, ready_q;
    logic [ERR_W-1:0]   retry_q, loss_q;
    logic               retry_inc, loss_inc;

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d   = state_q;
        retry_inc = 1'b0;
        loss_inc  = 1'b0;
        case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = PLL_RST;
                    retry_inc = 1'b1;
                end
            end
            STABLE: begin
                // A drop before qualification is treated as lock glitching, not a loss.
                if (!locked_s) state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = HOLD;
            end
            HOLD: begin
                if (!locked_s) begin
                    state_d  = WAIT_LOCK;
                    loss_inc = 1'b1;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d  = WAIT_LOCK;
                    loss_inc = 1'b1;
                end
            end
            default: state_d = PLL_RST;
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= PLL_RST;
            cnt_q        <= '0;
            sync_q       <= '0;
            pll_resetb_q <= 1'b0;
            soc_reset_q  <= 1'b1;
            ready_q      <= 1'b0;
            retry_q      <= '0;
            loss_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sync_q       <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked_async};
            // Outputs follow the next state so they change on the same edge as state_q.
            pll_resetb_q <= (state_d != PLL_RST);
            soc_reset_q  <= (state_d != RUN);
            ready_q      <= (state_d == RUN);
            if (bus.clear_counts) retry_q <= '0;
            else if (retry_inc && (retry_q != '1)) retry_q <= retry_q + 1'b1;
            if (bus.clear_counts) loss_q <= '0;
            else if (loss_inc && (loss_q != '1)) loss_q <= loss_q + 1'b1;
        end
    end

    assign bus.pll_resetb      = pll_resetb_q;
    assign bus.soc_reset       = soc_reset_q;
    assign bus.ready           = ready_q;
    assign bus.state           = state_q;
    assign bus.retry_count     = retry_q;
    assign bus.lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: a default-parameter instance for sequencing and
// lock-loss behaviour, and a short-timeout instance for retry counter saturation.
module tb_pll_reset_sequencer;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    pll_reset_sequencer_if #(.ERR_W(8)) if_a ();
    pll_reset_sequencer_if #(.ERR_W(8)) if_b ();

    pll_reset_sequencer dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (if_a)
    );

    pll_reset_sequencer #(
        .SYNC_STAGES        (2),
        .PLL_RST_CYCLES     (4),
        .LOCK_TIMEOUT       (16),
        .LOCK_STABLE_CYCLES (8),
        .RESET_HOLD_CYCLES  (4),
        .CNT_W              (8),
        .ERR_W              (8)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (if_b)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_a(input logic lock);
        rst_a = 1'b1;
        if_a.pll_locked_async = lock;
        if_a.clear_counts = 1'b0;
        step(3);
        rst_a = 1'b0;
    endtask

    task automatic wait_state_a(input logic [2:0] s, input int bound, output bit ok);
        int i;
        ok = 1'b0;
        i = 0;
        while (!ok && i < bound) begin
            step(1);
            if (if_a.state == s) ok = 1'b1;
            i++;
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        if_a.pll_locked_async = 1'b1;
        if_a.clear_counts = 1'b0;
        if_b.pll_locked_async = 1'b0;
        if_b.clear_counts = 1'b0;
        step(3);
        checks++; if (if_a.state !== 3'd0) $display("FAIL reset_state got %0d want 0", if_a.state); else passed++;
        checks++; if (if_a.pll_resetb !== 1'b0) $display("FAIL reset_pll_resetb got %b want 0", if_a.pll_resetb); else passed++;
        checks++; if (if_a.soc_reset !== 1'b1) $display("FAIL reset_soc_reset got %b want 1", if_a.soc_reset); else passed++;
        checks++; if (if_a.ready !== 1'b0) $display("FAIL reset_ready got %b want 0", if_a.ready); else passed++;
        checks++; if (if_a.retry_count !== 8'd0) $display("FAIL reset_retry got %0d want 0", if_a.retry_count); else passed++;
        checks++; if (if_a.lock_loss_count !== 8'd0) $display("FAIL reset_loss got %0d want 0", if_a.lock_loss_count); else passed++;
    endtask

    task automatic test_power_up();
        logic [14:0] seq;
        logic [2:0]  prev;
        int          lowcnt;
        rst_a = 1'b0;
        seq = 15'(if_a.state);
        prev = if_a.state;
        lowcnt = (if_a.pll_resetb == 1'b0) ? 1 : 0;
        for (int n = 1; n <= 340; n++) begin
            step(1);
            if (if_a.pll_resetb == 1'b0) lowcnt++;
            if (if_a.state != prev) begin
                seq = {seq[11:0], if_a.state};
                prev = if_a.state;
            end
            if (n == 15) begin
                checks++; if (if_a.pll_resetb !== 1'b0) $display("FAIL pu_resetb_e15 got %b want 0", if_a.pll_resetb); else passed++;
            end
            if (n == 16) begin
                checks++; if (if_a.pll_resetb !== 1'b1) $display("FAIL pu_resetb_e16 got %b want 1", if_a.pll_resetb); else passed++;
            end
            if (n == 336) begin
                checks++; if (if_a.soc_reset !== 1'b1) $display("FAIL pu_soc_reset_e336 got %b want 1", if_a.soc_reset); else passed++;
            end
            if (n == 337) begin
                checks++; if (if_a.soc_reset !== 1'b0) $display("FAIL pu_soc_reset_e337 got %b want 0", if_a.soc_reset); else passed++;
                checks++; if (if_a.ready !== 1'b1) $display("FAIL pu_ready_e337 got %b want 1", if_a.ready); else passed++;
            end
        end
        checks++; if (lowcnt !== 16) $display("FAIL pu_resetb_low_cycles got %0d want 16", lowcnt); else passed++;
        checks++; if (seq !== 15'o01234) $display("FAIL pu_state_seq got %o want 01234", seq); else passed++;
    endtask

    task automatic test_stable_glitch();
        bit sr_low;
        reset_a(1'b1);
        step(100);
        checks++; if (if_a.state !== 3'd2) $display("FAIL glitch_in_stable got %0d want 2", if_a.state); else passed++;
        if_a.pll_locked_async = 1'b0;
        sr_low = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            step(1);
            if (if_a.soc_reset == 1'b0) sr_low = 1'b1;
            if (n == 2) begin
                checks++; if (if_a.state !== 3'd2) $display("FAIL glitch_state_e2 got %0d want 2", if_a.state); else passed++;
            end
            if (n == 3) begin
                checks++; if (if_a.state !== 3'd1) $display("FAIL glitch_state_e3 got %0d want 1", if_a.state); else passed++;
            end
        end
        checks++; if (sr_low !== 1'b0) $display("FAIL glitch_soc_reset_released got %b want 0", sr_low); else passed++;
        checks++; if (if_a.lock_loss_count !== 8'd0) $display("FAIL glitch_loss got %0d want 0", if_a.lock_loss_count); else passed++;
    endtask

    task automatic test_timeout();
        logic prev;
        int   falls, first_fall, second_fall;
        reset_a(1'b0);
        prev = if_a.pll_resetb;
        falls = 0;
        first_fall = 0;
        second_fall = 0;
        for (int n = 1; n <= 8240; n++) begin
            step(1);
            if (prev == 1'b1 && if_a.pll_resetb == 1'b0) begin
                falls++;
                if (falls == 1) first_fall = n;
                if (falls == 2) second_fall = n;
            end
            prev = if_a.pll_resetb;
            if (n == 4111) begin
                checks++; if (if_a.retry_count !== 8'd0) $display("FAIL to_retry_e4111 got %0d want 0", if_a.retry_count); else passed++;
                checks++; if (if_a.state !== 3'd1) $display("FAIL to_state_e4111 got %0d want 1", if_a.state); else passed++;
            end
            if (n == 4112) begin
                checks++; if (if_a.retry_count !== 8'd1) $display("FAIL to_retry_e4112 got %0d want 1", if_a.retry_count); else passed++;
                checks++; if (if_a.state !== 3'd0) $display("FAIL to_state_e4112 got %0d want 0", if_a.state); else passed++;
            end
            if (n == 4127) begin
                checks++; if (if_a.pll_resetb !== 1'b0) $display("FAIL to_resetb_e4127 got %b want 0", if_a.pll_resetb); else passed++;
            end
            if (n == 4128) begin
                checks++; if (if_a.pll_resetb !== 1'b1) $display("FAIL to_resetb_e4128 got %b want 1", if_a.pll_resetb); else passed++;
            end
            if (n == 8224) begin
                checks++; if (if_a.retry_count !== 8'd2) $display("FAIL to_retry_e8224 got %0d want 2", if_a.retry_count); else passed++;
            end
        end
        checks++; if (first_fall !== 4112) $display("FAIL to_first_pulse got %0d want 4112", first_fall); else passed++;
        checks++; if (second_fall - first_fall !== 4112) $display("FAIL to_pulse_period got %0d want 4112", second_fall - first_fall); else passed++;
    endtask

    task automatic test_run_lock_loss();
        reset_a(1'b1);
        step(337);
        checks++; if (if_a.state !== 3'd4) $display("FAIL rl_in_run got %0d want 4", if_a.state); else passed++;
        if_a.pll_locked_async = 1'b0;
        step(2);
        checks++; if (if_a.soc_reset !== 1'b0) $display("FAIL rl_soc_reset_e2 got %b want 0", if_a.soc_reset); else passed++;
        step(1);
        checks++; if (if_a.soc_reset !== 1'b1) $display("FAIL rl_soc_reset_e3 got %b want 1", if_a.soc_reset); else passed++;
        checks++; if (if_a.ready !== 1'b0) $display("FAIL rl_ready_e3 got %b want 0", if_a.ready); else passed++;
        checks++; if (if_a.state !== 3'd1) $display("FAIL rl_state_e3 got %0d want 1", if_a.state); else passed++;
        checks++; if (if_a.lock_loss_count !== 8'd1) $display("FAIL rl_loss got %0d want 1", if_a.lock_loss_count); else passed++;
        if_a.pll_locked_async = 1'b1;
        step(322);
        checks++; if (if_a.soc_reset !== 1'b1) $display("FAIL rl_relock_e322 got %b want 1", if_a.soc_reset); else passed++;
        step(1);
        checks++; if (if_a.soc_reset !== 1'b0) $display("FAIL rl_relock_e323 got %b want 0", if_a.soc_reset); else passed++;
        checks++; if (if_a.state !== 3'd4) $display("FAIL rl_relock_state got %0d want 4", if_a.state); else passed++;
    endtask

    task automatic test_hold_reset();
        bit ok;
        for (int k = 0; k < 4; k++) begin
            if_a.pll_locked_async = 1'b0;
            wait_state_a(3'd1, 10, ok);
            checks++; if (ok !== 1'b1) $display("FAIL hr_reach_wait_lock iter %0d got state %0d want 1", k, if_a.state); else passed++;
            if_a.pll_locked_async = 1'b1;
            wait_state_a(3'd3, 400, ok);
            checks++; if (ok !== 1'b1) $display("FAIL hr_reach_hold iter %0d got state %0d want 3", k, if_a.state); else passed++;
        end
        checks++; if (if_a.lock_loss_count !== 8'd5) $display("FAIL hr_loss_before got %0d want 5", if_a.lock_loss_count); else passed++;
        step(10);
        checks++; if (if_a.state !== 3'd3) $display("FAIL hr_mid_hold got %0d want 3", if_a.state); else passed++;
        rst_a = 1'b1;
        step(1);
        rst_a = 1'b0;
        checks++; if (if_a.state !== 3'd0) $display("FAIL hr_state got %0d want 0", if_a.state); else passed++;
        checks++; if (if_a.pll_resetb !== 1'b0) $display("FAIL hr_pll_resetb got %b want 0", if_a.pll_resetb); else passed++;
        checks++; if (if_a.soc_reset !== 1'b1) $display("FAIL hr_soc_reset got %b want 1", if_a.soc_reset); else passed++;
        checks++; if (if_a.lock_loss_count !== 8'd0) $display("FAIL hr_loss got %0d want 0", if_a.lock_loss_count); else passed++;
        checks++; if (if_a.retry_count !== 8'd0) $display("FAIL hr_retry got %0d want 0", if_a.retry_count); else passed++;
    endtask

    task automatic test_clear_same_edge();
        bit ok;
        reset_a(1'b1);
        step(337);
        if_a.pll_locked_async = 1'b0;
        step(3);
        checks++; if (if_a.lock_loss_count !== 8'd1) $display("FAIL cs_loss_pre got %0d want 1", if_a.lock_loss_count); else passed++;
        if_a.pll_locked_async = 1'b1;
        wait_state_a(3'd4, 400, ok);
        checks++; if (ok !== 1'b1) $display("FAIL cs_back_to_run got state %0d want 4", if_a.state); else passed++;
        if_a.pll_locked_async = 1'b0;
        step(2);
        if_a.clear_counts = 1'b1;
        step(1);
        if_a.clear_counts = 1'b0;
        checks++; if (if_a.lock_loss_count !== 8'd0) $display("FAIL cs_loss got %0d want 0", if_a.lock_loss_count); else passed++;
        checks++; if (if_a.state !== 3'd1) $display("FAIL cs_state got %0d want 1", if_a.state); else passed++;
        checks++; if (if_a.soc_reset !== 1'b1) $display("FAIL cs_soc_reset got %b want 1", if_a.soc_reset); else passed++;
    endtask

    task automatic test_retry_saturation();
        rst_b = 1'b1;
        if_b.pll_locked_async = 1'b0;
        if_b.clear_counts = 1'b0;
        step(2);
        rst_b = 1'b0;
        step(20);
        checks++; if (if_b.retry_count !== 8'd1) $display("FAIL sat_retry_e20 got %0d want 1", if_b.retry_count); else passed++;
        step(19);
        checks++; if (if_b.retry_count !== 8'd1) $display("FAIL sat_retry_e39 got %0d want 1", if_b.retry_count); else passed++;
        step(1);
        checks++; if (if_b.retry_count !== 8'd2) $display("FAIL sat_retry_e40 got %0d want 2", if_b.retry_count); else passed++;
        step(20 * 252 + 19);
        checks++; if (if_b.retry_count !== 8'd254) $display("FAIL sat_retry_e5099 got %0d want 254", if_b.retry_count); else passed++;
        step(1);
        checks++; if (if_b.retry_count !== 8'd255) $display("FAIL sat_retry_e5100 got %0d want 255", if_b.retry_count); else passed++;
        step(20 * 5);
        checks++; if (if_b.retry_count !== 8'd255) $display("FAIL sat_retry_hold got %0d want 255", if_b.retry_count); else passed++;
        if_b.clear_counts = 1'b1;
        step(1);
        if_b.clear_counts = 1'b0;
        checks++; if (if_b.retry_count !== 8'd0) $display("FAIL sat_clear got %0d want 0", if_b.retry_count); else passed++;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_stable_glitch();
        test_timeout();
        test_run_lock_loss();
        test_hold_reset();
        test_clear_same_edge();
        test_retry_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
